turn_sequencer: RTL and testbench

TURN_SEQUENCER -- requirements
Module: turn_sequencer

---
 rtl/turn_sequencer_pkg.sv | 19 +
 rtl/turn_sequencer_aim_reg.sv | 54 +++++
 rtl/turn_sequencer.sv | 173 +++++++++++++++++
 tb/tb_turn_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_sequencer_pkg.sv
// Shared definitions for the turn sequencer: state encoding, aim limits and
// the aim values each player starts a game with.
package turn_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_AIM    = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_ARM    = 3'd2,
      ST_FLIGHT = 3'd3,
      ST_SETTLE = 3'd4
   } state_e;

   localparam logic [3:0] ANGLE_MAX    = 4'd8;
   localparam logic [2:0] POWER_MAX    = 3'd7;
   localparam logic [3:0] P0_ANGLE_RST = 4'd6;
   localparam logic [3:0] P1_ANGLE_RST = 4'd2;
   localparam logic [2:0] POWER_RST    = 3'd3;

endpackage

// File: rtl/turn_sequencer_aim_reg.sv
// One player's aim: angle and power with saturating single steps.
// Opposing directions pressed together cancel each other out.
module aim_reg
   import turn_sequencer_pkg::*;
#(
   parameter logic [3:0] ANGLE_RST = P0_ANGLE_RST
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       step_en_i,
   input  logic       left_i,
   input  logic       right_i,
   input  logic       up_i,
   input  logic       down_i,
   output logic [3:0] angle_o,
   output logic [2:0] power_o
);

   logic [3:0] angle_q, angle_d;
   logic [2:0] power_q, power_d;

   // Work out the stepped angle/power, clamping at the ends of each range.
   always_comb begin
      angle_d = angle_q;
      power_d = power_q;
      if (step_en_i) begin
         if (left_i && !right_i && angle_q != 4'd0) begin
            angle_d = angle_q - 4'd1;
         end else if (right_i && !left_i && angle_q < ANGLE_MAX) begin
            angle_d = angle_q + 4'd1;
         end
         if (up_i && !down_i && power_q < POWER_MAX) begin
            power_d = power_q + 3'd1;
         end else if (down_i && !up_i && power_q != 3'd0) begin
            power_d = power_q - 3'd1;
         end
      end
   end

   // Hold the aim; reset restores this player's starting values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         angle_q <= ANGLE_RST;
         power_q <= POWER_RST;
      end else begin
         angle_q <= angle_d;
         power_q <= power_d;
      end
   end

   assign angle_o = angle_q;
   assign power_o = power_q;

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer for a two-player artillery game: aiming with auto-repeat,
// launch handshake with the bomb, flight, settle pause and player hand-over.
module turn_sequencer
   import turn_sequencer_pkg::*;
#(
   parameter int SETTLE_FRAMES = 30,
   parameter int REPEAT_FRAMES = 8,
   parameter int ARM_TIMEOUT   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_clk,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_fire,
   input  logic       boom,
   input  logic [9:0] p0_x,
   input  logic [9:0] p0_y,
   input  logic [9:0] p1_x,
   input  logic [9:0] p1_y,
   output logic       launch,
   output logic [9:0] launchX,
   output logic [9:0] launchY,
   output logic [3:0] angle,
   output logic [2:0] power,
   output logic       active_player,
   output logic       aiming,
   output logic [2:0] state_dbg
);

   localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_FRAMES - 1);
   localparam logic [7:0] ARM_LAST    = 8'(ARM_TIMEOUT - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FRAMES - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       player_q, player_d;
   logic       launch_q, launch_d;
   logic       sync1_q, sync2_q, sync3_q;
   logic       fire_q;
   logic       frameTick, fireEdge, dirHeld, stepEn;
   logic [3:0] angle0, angle1;
   logic [2:0] power0, power1;

   assign frameTick = sync2_q & ~sync3_q;
   assign fireEdge  = btn_fire & ~fire_q;
   assign dirHeld   = btn_left | btn_right | btn_up | btn_down;

   // Bring frame_clk into the clk domain and remember last cycle's fire level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         fire_q  <= 1'b0;
      end else begin
         sync1_q <= frame_clk;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         fire_q  <= btn_fire;
      end
   end

   // Next state, shared frame counter, aim step strobe and player hand-over.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      player_d = player_q;
      stepEn   = 1'b0;
      case (state_q)
         ST_AIM: begin
            if (!dirHeld) begin
               cnt_d = 8'd0;
            end else if (frameTick) begin
               stepEn = (cnt_q == 8'd0);
               cnt_d  = (cnt_q == REPEAT_LAST) ? 8'd0 : cnt_q + 8'd1;
            end
            if (fireEdge) begin
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (frameTick) begin
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            if (!boom) begin
               state_d = ST_FLIGHT;
            end else if (frameTick) begin
               if (cnt_q == ARM_LAST) begin
                  state_d = ST_AIM;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_FLIGHT: begin
            if (boom) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (frameTick) begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d  = ST_AIM;
                  player_d = ~player_q;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_AIM;
         end
      endcase
      if (state_d != state_q) begin
         cnt_d = 8'd0;
      end
      launch_d = (state_d == ST_LAUNCH);
   end

   // State, counter, active player and the registered launch strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_AIM;
         cnt_q    <= 8'd0;
         player_q <= 1'b0;
         launch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         player_q <= player_d;
         launch_q <= launch_d;
      end
   end

   aim_reg #(.ANGLE_RST(P0_ANGLE_RST)) u_aim0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .step_en_i (stepEn & ~player_q),
      .left_i    (btn_left),
      .right_i   (btn_right),
      .up_i      (btn_up),
      .down_i    (btn_down),
      .angle_o   (angle0),
      .power_o   (power0)
   );

   aim_reg #(.ANGLE_RST(P1_ANGLE_RST)) u_aim1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .step_en_i (stepEn & player_q),
      .left_i    (btn_left),
      .right_i   (btn_right),
      .up_i      (btn_up),
      .down_i    (btn_down),
      .angle_o   (angle1),
      .power_o   (power1)
   );

   assign launch        = launch_q;
   assign active_player = player_q;
   assign aiming        = (state_q == ST_AIM);
   assign state_dbg     = state_q;
   assign launchX       = player_q ? p1_x : p0_x;
   assign launchY       = player_q ? p1_y : p0_y;
   assign angle         = player_q ? angle1 : angle0;
   assign power         = player_q ? power1 : power0;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: a turn-level model of the game
// rules is compared against the DUT on every clk, plus directed scenarios
// with hand-computed expectations and a randomized button/bomb phase.
module tb_turn_sequencer;

   localparam int SETTLE     = 30;
   localparam int REPEAT     = 8;
   localparam int ARMTO      = 4;
   localparam int FRAME_HALF = 50;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_clk = 1'b0;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_fire = 1'b0;
   logic       boom = 1'b1;
   logic [9:0] p0_x = 10'd100, p0_y = 10'd400, p1_x = 10'd900, p1_y = 10'd380;
   logic       launch, active_player, aiming;
   logic [9:0] launchX, launchY;
   logic [3:0] angle;
   logic [2:0] power;
   logic [2:0] state_dbg;

   int passCount  = 0;
   int checkCount = 0;
   bit compareOn  = 1'b0;

   // Model of the game: 0 AIM, 1 LAUNCH, 2 ARM, 3 FLIGHT, 4 SETTLE.
   int mState = 0, mPlayer = 0;
   int mAngle[2], mPower[2];
   int mHeld = 0, mArm = 0, mSettle = 0;
   int tickCount = 0;
   logic [2:0] mSync = 3'b000;
   bit mFireHist = 1'b0;

   turn_sequencer #(
      .SETTLE_FRAMES (SETTLE),
      .REPEAT_FRAMES (REPEAT),
      .ARM_TIMEOUT   (ARMTO)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .frame_clk     (frame_clk),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .btn_fire      (btn_fire),
      .boom          (boom),
      .p0_x          (p0_x),
      .p0_y          (p0_y),
      .p1_x          (p1_x),
      .p1_y          (p1_y),
      .launch        (launch),
      .launchX       (launchX),
      .launchY       (launchY),
      .angle         (angle),
      .power         (power),
      .active_player (active_player),
      .aiming        (aiming),
      .state_dbg     (state_dbg)
   );

   // System clock, 10 ns period.
   always #5 clk = ~clk;

   // Frame clock: a slow square wave, one frame every 2*FRAME_HALF clk.
   initial begin
      forever begin
         repeat (FRAME_HALF) @(negedge clk);
         frame_clk = ~frame_clk;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit l, input bit r, input bit u, input bit d, input bit f);
      btn_left  = l;
      btn_right = r;
      btn_up    = u;
      btn_down  = d;
      btn_fire  = f;
   endtask

   task automatic waitTicks(input int n);
      int start = tickCount;
      int budget = n * 2 * FRAME_HALF + 20;
      int spent = 0;
      while ((tickCount - start) < n && spent < budget) begin
         @(negedge clk);
         spent++;
      end
      if ((tickCount - start) < n) checkOutput("tick wait", tickCount - start, n);
   endtask

   task automatic waitState(input int target, input int budget);
      int spent = 0;
      while (mState != target && spent < budget) begin
         @(negedge clk);
         spent++;
      end
      if (mState != target) checkOutput("state wait", mState, target);
   endtask

   // Behavioural reference: applies the game rules once per clk.
   always @(posedge clk or negedge reset_n) begin : modelProc
      int nState, nPlayer, nHeld, nArm, nSettle;
      int nAng[2];
      int nPow[2];
      bit tickNow, fireEdgeNow, anyDir;
      if (!reset_n) begin
         mState    <= 0;
         mPlayer   <= 0;
         mAngle[0] <= 6;
         mAngle[1] <= 2;
         mPower[0] <= 3;
         mPower[1] <= 3;
         mHeld     <= 0;
         mArm      <= 0;
         mSettle   <= 0;
         mSync     <= 3'b000;
         mFireHist <= 1'b0;
      end else begin
         nState  = mState;
         nPlayer = mPlayer;
         nHeld   = mHeld;
         nArm    = mArm;
         nSettle = mSettle;
         nAng[0] = mAngle[0];
         nAng[1] = mAngle[1];
         nPow[0] = mPower[0];
         nPow[1] = mPower[1];
         tickNow     = mSync[1] && !mSync[2];
         fireEdgeNow = btn_fire && !mFireHist;
         anyDir      = btn_left || btn_right || btn_up || btn_down;
         case (mState)
            0: begin
               if (!anyDir) begin
                  nHeld = 0;
               end else if (tickNow) begin
                  if (mHeld % REPEAT == 0) begin
                     if (btn_right && !btn_left) nAng[mPlayer] = (nAng[mPlayer] >= 8) ? 8 : nAng[mPlayer] + 1;
                     if (btn_left && !btn_right) nAng[mPlayer] = (nAng[mPlayer] <= 0) ? 0 : nAng[mPlayer] - 1;
                     if (btn_up && !btn_down)    nPow[mPlayer] = (nPow[mPlayer] >= 7) ? 7 : nPow[mPlayer] + 1;
                     if (btn_down && !btn_up)    nPow[mPlayer] = (nPow[mPlayer] <= 0) ? 0 : nPow[mPlayer] - 1;
                  end
                  nHeld = mHeld + 1;
               end
               if (fireEdgeNow) nState = 1;
            end
            1: if (tickNow) nState = 2;
            2: begin
               if (!boom) begin
                  nState = 3;
               end else if (tickNow) begin
                  nArm = mArm + 1;
                  if (nArm == ARMTO) nState = 0;
               end
            end
            3: if (boom) nState = 4;
            default: begin
               if (tickNow) begin
                  nSettle = mSettle + 1;
                  if (nSettle == SETTLE) begin
                     nState  = 0;
                     nPlayer = 1 - mPlayer;
                  end
               end
            end
         endcase
         if (nState != mState) begin
            nHeld   = 0;
            nArm    = 0;
            nSettle = 0;
         end
         if (tickNow) tickCount <= tickCount + 1;
         mState    <= nState;
         mPlayer   <= nPlayer;
         mHeld     <= nHeld;
         mArm      <= nArm;
         mSettle   <= nSettle;
         mAngle[0] <= nAng[0];
         mAngle[1] <= nAng[1];
         mPower[0] <= nPow[0];
         mPower[1] <= nPow[1];
         mSync     <= {mSync[1:0], frame_clk};
         mFireHist <= btn_fire;
      end
   end

   // Compare every DUT output against the model away from the active edge.
   always @(negedge clk) begin
      if (compareOn) begin
         checkOutput("state_dbg", state_dbg, mState);
         checkOutput("launch", launch, (mState == 1) ? 1 : 0);
         checkOutput("aiming", aiming, (mState == 0) ? 1 : 0);
         checkOutput("active_player", active_player, mPlayer);
         checkOutput("angle", angle, mAngle[mPlayer]);
         checkOutput("power", power, mPower[mPlayer]);
         checkOutput("launchX", launchX, (mPlayer == 1) ? p1_x : p0_x);
         checkOutput("launchY", launchY, (mPlayer == 1) ? p1_y : p0_y);
      end
   end

   // Absolute time limit so the run always ends.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passCount, checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized play.
   initial begin
      repeat (3) @(negedge clk);
      compareOn = 1'b1;
      checkOutput("reset state", state_dbg, 0);
      checkOutput("reset launch", launch, 0);
      checkOutput("reset player", active_player, 0);
      checkOutput("reset angle", angle, 6);
      checkOutput("reset power", power, 3);
      checkOutput("reset launchX", launchX, 100);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Fire edge from player 0, then bomb never leaves boom: arm timeout.
      applyStimulus(0, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("launch high", launch, 1);
      checkOutput("launch state", state_dbg, 1);
      checkOutput("launch X p0", launchX, 100);
      checkOutput("launch Y p0", launchY, 400);
      checkOutput("launch angle", angle, 6);
      checkOutput("launch power", power, 3);
      applyStimulus(0, 0, 0, 0, 0);
      waitState(2, 4 * FRAME_HALF);
      checkOutput("arm state", state_dbg, 2);
      checkOutput("arm launch low", launch, 0);
      waitTicks(3);
      checkOutput("arm still waiting", state_dbg, 2);
      waitTicks(1);
      checkOutput("arm timeout state", state_dbg, 0);
      checkOutput("arm timeout player", active_player, 0);

      // Hold right for 20 ticks: steps on ticks 1, 9 and 17.
      @(negedge clk);
      applyStimulus(0, 1, 0, 0, 0);
      waitTicks(1);
      checkOutput("repeat tick1", angle, 7);
      waitTicks(7);
      checkOutput("repeat tick8", angle, 7);
      waitTicks(1);
      checkOutput("repeat tick9", angle, 8);
      waitTicks(11);
      checkOutput("repeat tick20", angle, 8);
      checkOutput("repeat power", power, 3);
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);

      // Full turn with fire held throughout.
      applyStimulus(0, 0, 0, 0, 1);
      waitState(2, 4 * FRAME_HALF);
      boom = 1'b0;
      waitState(3, 10);
      waitTicks(10);
      boom = 1'b1;
      waitState(4, 10);
      checkOutput("settle state", state_dbg, 4);
      waitTicks(SETTLE - 1);
      checkOutput("settle holding", state_dbg, 4);
      waitTicks(1);
      checkOutput("turn state", state_dbg, 0);
      checkOutput("turn player", active_player, 1);
      checkOutput("turn angle", angle, 2);
      checkOutput("turn power", power, 3);
      checkOutput("turn launchX", launchX, 900);
      repeat (300) @(negedge clk);
      checkOutput("held fire no relaunch", launch, 0);
      checkOutput("held fire stays aim", state_dbg, 0);
      applyStimulus(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      applyStimulus(0, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("p1 launch", launch, 1);
      checkOutput("p1 launchX", launchX, 900);
      checkOutput("p1 launchY", launchY, 380);
      checkOutput("p1 angle", angle, 2);
      applyStimulus(0, 0, 0, 0, 0);
      waitState(2, 4 * FRAME_HALF);
      waitTicks(ARMTO);
      checkOutput("p1 timeout state", state_dbg, 0);
      checkOutput("p1 timeout player", active_player, 1);

      // Reset in the middle of LAUNCH.
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst launch: launch", launch, 0);
      checkOutput("rst launch: state", state_dbg, 0);
      checkOutput("rst launch: player", active_player, 0);
      checkOutput("rst launch: angle", angle, 6);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Reset in the middle of FLIGHT.
      applyStimulus(0, 0, 0, 0, 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0);
      waitState(2, 4 * FRAME_HALF);
      boom = 1'b0;
      waitState(3, 10);
      waitTicks(2);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      checkOutput("rst flight: launch", launch, 0);
      checkOutput("rst flight: state", state_dbg, 0);
      checkOutput("rst flight: aiming", aiming, 1);
      checkOutput("rst flight: player", active_player, 0);
      checkOutput("rst flight: angle", angle, 6);
      checkOutput("rst flight: power", power, 3);
      checkOutput("rst flight: launchX", launchX, 100);
      repeat (2) @(negedge clk);
      boom = 1'b1;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Randomized buttons and bomb behaviour, checked by the model.
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3) == 0);
         boom = ($urandom_range(0, 4) != 0);
         repeat ($urandom_range(20, 300)) @(negedge clk);
      end

      compareOn = 1'b0;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
